bcd_seq_multiplier: RTL and testbench
=====================================

# bcd_seq_multiplier

Sequential multi-digit BCD multiplier, the parametrised successor of the single-digit combinational BCD multiplier. Two DIGITS-digit packed BCD operands are multiplied digit-serially by shift-and-add directly in BCD, with no binary conversion, and produce a 2·DIGITS-digit BCD product. The block uses a start/busy/done handshake and per-operand invalid-digit flags. It sits between the operand entry logic and the display/result registers of the arithmetic datapath.

## Interface
- DIGITS, 4, BCD digits per operand (≥1); product has 2·DIGITS digits
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted on an edge where start=1 and busy=0
- a  in  4·DIGITS  multiplicand, packed BCD; most significant nibble at MSBs
- b  in  4·DIGITS  multiplier, packed BCD; same packing
- busy  out  1  high while computing (SHIFT/ADD states)
- done  out  1  one-cycle pulse; product/err valid in that cycle
- product  out  8·DIGITS  packed BCD result; held until the next accept
- err_a  out  1  a contained a nibble > 9 at accept
- err_b  out  1  b contained a nibble > 9 at accept

## Operation
- States: IDLE, SHIFT, ADD, FINISH.
- Accept: on any edge with start=1 and state IDLE or FINISH:
  - capture a→A_r and b→B_r;
  - clear accumulator P;
  - set digit index i=DIGITS-1, the MSD of B_r;
  - compute err_a/err_b.
- Invalid operand (either flag set): next state FINISH, P forced to 0. Flags report both operands independently.
- Valid operands: next state SHIFT.
- SHIFT:
  - P ← P·10, a left shift of one nibble; the top nibble is discarded and is always 0 by construction.
  - Load add counter c ← B_r digit i.
  - If c=0: next state is SHIFT with i−1, or FINISH if i=0. Otherwise next state is ADD.
- ADD:
  - P ← P + A_r, aligned at the LSD, using a ripple BCD digit-adder chain over all 2·DIGITS digits.
  - c ← c−1. When c reaches 0: next state is SHIFT with i−1, or FINISH if i=0.
- FINISH: done=1 for exactly one cycle, then IDLE unless a new start is accepted in that cycle.
- Arithmetic: each digit sum is binary a+b+cin (0..19). If the sum is >9, add 6 and set carry-out. The final carry never overflows, since the product is at most (10^DIGITS−1)^2.
- While busy, start, a and b are ignored. Only A_r/B_r are used.
- product is driven from P. It updates only when FINISH is entered and is otherwise stable.
- reset (including mid-operation): state IDLE, P=0, product=0, busy=0, done=0, err_a=0, err_b=0. Any operation in progress is discarded.

## Timing
- Accept edge = k. Define S = sum of the decimal digits of b.
- Valid operands: busy=1 for cycles k+1 … k+DIGITS+S; done=1 in cycle k+DIGITS+S+1.
- Latency therefore ranges from DIGITS+1 (b=0) to 10·DIGITS+1 (b all 9s).
- Invalid operands: done=1 in cycle k+1; busy never asserts.
- err_a/err_b update at the FINISH entry edge, together with product, and hold until the next FINISH.
- Back-to-back: start=1 during the done cycle is accepted. busy rises in the next cycle, and product holds the old result until the new FINISH.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package bcd_pkg contains:
  - DIGIT_W=4;
  - the state encoding (IDLE, SHIFT, ADD, FINISH);
  - function is_bcd_digit(nibble).
- Sub-module bcd_digit_adder: inputs 4-bit x, y and cin; outputs 4-bit s and cout, with the +6 correction.
- The top level generates a chain of 2·DIGITS bcd_digit_adder instances, with A_r zero-extended to 2·DIGITS digits.
- The FSM, counter c, index i, P register and validity check live in the top level.

## Test plan
- Reset mid-operation: assert reset during ADD. Next cycle: busy=0, done=0, product=0, flags 0. A start after reset completes normally.
- DIGITS=4, a=0x1234, b=0x0567. Expect product=0x00699678 and done in cycle k+23 (4+18+1). busy high for exactly 22 cycles.
- DIGITS=4, a=0x9999, b=0x9999. Expect product=0x99980001 and done at k+41. Verify carries ripple through all 8 digits.
- a=0x0000, b=0x0005 gives product 0, done at k+10. a=0x4321, b=0x0000 gives product 0, done at k+5 (no ADD cycles).
- Invalid operands:
  - a=0x12A4, b=0x0003: err_a=1, err_b=0, product=0, done at k+1, busy never high.
  - a=0xF000, b=0x00B0: both flags set.
  - A following valid start clears both flags.
- Handshake:
  - start pulses and changes to a/b while busy are ignored; the result matches the captured operands.
  - start during the done cycle is accepted; the new result appears without an intervening idle cycle.
  - Run random valid operands against a decimal reference model for DIGITS=1, 2 and 4.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic blocks: digit width, the
// sequential multiplier's state encoding and a BCD digit validity test.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ADD,
    FINISH
  } state_e;

  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit of a ripple adder: binary x+y+cin, then +6 correction and
// carry-out whenever the binary sum exceeds 9.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W:0] raw;

  always_comb begin
    raw  = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
    cout = raw > 5'd9;
    // Adding 6 modulo 16 to the low nibble yields the corrected digit.
    s    = cout ? raw[DIGIT_W-1:0] + 4'd6 : raw[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_seq_multiplier.sv
// Digit-serial BCD multiplier: shift-and-add directly in BCD, one multiplier
// digit per SHIFT followed by that many ADD cycles, start/busy/done handshake.
module bcd_seq_multiplier
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DIGIT_W*DIGITS-1:0]     a,
  input  logic [DIGIT_W*DIGITS-1:0]     b,
  output logic                          busy,
  output logic                          done,
  output logic [2*DIGIT_W*DIGITS-1:0]   product,
  output logic                          err_a,
  output logic                          err_b
);

  localparam int OP_W   = DIGIT_W * DIGITS;
  localparam int PROD_W = 2 * OP_W;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic [OP_W-1:0]     a_r_q, a_r_d, b_r_q, b_r_d;
  logic [DIGIT_W-1:0]  c_q, c_d;
  logic [IDX_W-1:0]    i_q, i_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                err_a_q, err_a_d, err_b_q, err_b_d;

  logic                a_ok, b_ok;
  logic [DIGIT_W-1:0]  b_digit;
  logic [PROD_W-1:0]   a_ext, sum;
  logic [2*DIGITS:0]   carry;
  logic                unused_carry;

  always_comb begin
    a_ok = 1'b1;
    b_ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (!is_bcd_digit(a[d*DIGIT_W +: DIGIT_W])) a_ok = 1'b0;
      if (!is_bcd_digit(b[d*DIGIT_W +: DIGIT_W])) b_ok = 1'b0;
    end
  end

  assign b_digit      = b_r_q[i_q*DIGIT_W +: DIGIT_W];
  assign a_ext        = {{OP_W{1'b0}}, a_r_q};
  assign carry[0]     = 1'b0;
  // The product never exceeds 2*DIGITS digits, so the final carry is always 0.
  assign unused_carry = carry[2*DIGITS];

  for (genvar g = 0; g < 2 * DIGITS; g++) begin : g_add
    bcd_digit_adder u_digit (
      .x    (p_q[g*DIGIT_W +: DIGIT_W]),
      .y    (a_ext[g*DIGIT_W +: DIGIT_W]),
      .cin  (carry[g]),
      .s    (sum[g*DIGIT_W +: DIGIT_W]),
      .cout (carry[g+1])
    );
  end

  always_comb begin
    logic finish_valid;
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    p_d          = p_q;
    product_d    = product_q;
    a_r_d        = a_r_q;
    b_r_d        = b_r_q;
    c_d          = c_q;
    i_d          = i_q;
    err_a_d      = err_a_q;
    err_b_d      = err_b_q;
    finish_valid = 1'b0;

    unique case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          a_r_d = a;
          b_r_d = b;
          p_d   = '0;
          c_d   = '0;
          i_d   = IDX_W'(DIGITS - 1);
          if (!a_ok || !b_ok) begin
            state_d   = FINISH;
            product_d = '0;
            err_a_d   = !a_ok;
            err_b_d   = !b_ok;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        p_d = {p_q[PROD_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
        c_d = b_digit;
        if (b_digit != '0) begin
          state_d = ADD;
        end else if (i_q == '0) begin
          state_d      = FINISH;
          finish_valid = 1'b1;
        end else begin
          i_d = i_q - 1'b1;
        end
      end
      ADD: begin
        p_d = sum;
        c_d = c_q - 4'd1;
        if (c_q == 4'd1) begin
          if (i_q == '0) begin
            state_d      = FINISH;
            finish_valid = 1'b1;
          end else begin
            state_d = SHIFT;
            i_d     = i_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish_valid) begin
      product_d = p_d;
      err_a_d   = 1'b0;
      err_b_d   = 1'b0;
    end

    busy_d = (state_d == SHIFT) || (state_d == ADD);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      p_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_a_q   <= 1'b0;
      err_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_a_q   <= err_a_d;
      err_b_q   <= err_b_d;
    end
  end

  // NOTE: operand, counter and index registers are always loaded at accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    a_r_q <= a_r_d;
    b_r_q <= b_r_d;
    c_q   <= c_d;
    i_q   <= i_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign err_a   = err_a_q;
  assign err_b   = err_b_q;

endmodule

// File: tb/tb_bcd_seq_multiplier.sv
// Directed and randomised checks of bcd_seq_multiplier (DIGITS=4): products,
// done latency, busy length, error flags, reset abort and back-to-back starts.
module tb_bcd_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] a, b;
  logic        busy, done, err_a, err_b;
  logic [31:0] product;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] last_prod = '0;
  bit          nxt_valid = 1'b0;
  logic [15:0] nxt_a, nxt_b;

  bcd_seq_multiplier #(.DIGITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .err_a   (err_a),
    .err_b   (err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int xv = 0;
    int yv = 0;
    int p;
    logic [31:0] r = '0;
    for (int d = 3; d >= 0; d--) begin
      xv = xv * 10 + int'(x[d*4 +: 4]);
      yv = yv * 10 + int'(y[d*4 +: 4]);
    end
    p = xv * yv;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  function automatic int digit_sum(input logic [15:0] y);
    int s = 0;
    for (int d = 0; d < 4; d++) s += int'(y[d*4 +: 4]);
    return s;
  endfunction

  // Called at a negedge. Drives the operands (unless already started by the
  // previous op), waits for done, checks latency/busy/product/flags.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [31:0] ep, input int elat,
                        input logic eea, input logic eeb, input string tag,
                        input bit pre_started, input bit disturb);
    int n = 0;
    int busy_n = 0;
    bit seen = 1'b0;
    if (!pre_started) begin
      start = 1'b1;
      a     = ta;
      b     = tb_v;
    end
    while (!seen && n < 150) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        a     = 16'h5555;
        b     = 16'h5555;
        if (elat > 1) check({tag, "_held"}, product, last_prod);
      end
      if (disturb && n == 2) begin
        start = 1'b1;
        a     = 16'h9999;
        b     = 16'h9999;
      end
      if (disturb && n == 3) start = 1'b0;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(n), 32'(elat));
    check({tag, "_prod"}, product, ep);
    check({tag, "_erra"}, {31'b0, err_a}, {31'b0, eea});
    check({tag, "_errb"}, {31'b0, err_b}, {31'b0, eeb});
    check({tag, "_busy"}, 32'(busy_n), 32'(elat - 1));
    last_prod = ep;
    if (nxt_valid) begin
      start     = 1'b1;
      a         = nxt_a;
      b         = nxt_b;
      nxt_valid = 1'b0;
    end else begin
      start = 1'b0;
      @(negedge clk);
      check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_prod", product, 32'd0);
    check("rst_err", {30'b0, err_a, err_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h0567, 32'h00699678, 23, 1'b0, 1'b0, "m1234x567", 1'b0, 1'b0);
    run_op(16'h9999, 16'h9999, 32'h99980001, 41, 1'b0, 1'b0, "m9999sq",   1'b0, 1'b0);
    run_op(16'h0000, 16'h0005, 32'h00000000, 10, 1'b0, 1'b0, "m0x5",      1'b0, 1'b0);
    run_op(16'h4321, 16'h0000, 32'h00000000,  5, 1'b0, 1'b0, "m4321x0",   1'b0, 1'b0);
    run_op(16'h12A4, 16'h0003, 32'h00000000,  1, 1'b1, 1'b0, "inv_a",     1'b0, 1'b0);
    run_op(16'hF000, 16'h00B0, 32'h00000000,  1, 1'b1, 1'b1, "inv_ab",    1'b0, 1'b0);
    run_op(16'h0002, 16'h0003, 32'h00000006,  8, 1'b0, 1'b0, "clr_flags", 1'b0, 1'b0);
    run_op(16'h1234, 16'h0567, 32'h00699678, 23, 1'b0, 1'b0, "ignore",    1'b0, 1'b1);

    nxt_valid = 1'b1;
    nxt_a     = 16'h0011;
    nxt_b     = 16'h0012;
    run_op(16'h0025, 16'h0004, 32'h00000100, 9, 1'b0, 1'b0, "b2b_first",  1'b0, 1'b0);
    run_op(16'h0011, 16'h0012, 32'h00000132, 8, 1'b0, 1'b0, "b2b_second", 1'b1, 1'b0);

    // Abort during the first ADD cycle (cycle k+3) of 1234 x 0567.
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h0567;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_abort_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_prod", product, 32'd0);
    check("abort_err", {30'b0, err_a, err_b}, 32'd0);
    last_prod = '0;
    run_op(16'h0007, 16'h0008, 32'h00000056, 13, 1'b0, 1'b0, "after_rst", 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < 4; d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      run_op(ra, rb, ref_mul(ra, rb), 4 + digit_sum(rb) + 1, 1'b0, 1'b0,
             $sformatf("rnd%0d", k), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
